// File: rtl/conbus_pkg.sv
// Shared constants, master-field bundle and round-robin helper for the
// parametrised shared-bus Wishbone interconnect.
package conbus_pkg;

   localparam int WB_DW     = 32;
   localparam int WB_AW     = 32;
   localparam int WB_CTIW   = 3;
   localparam int WB_SELW   = 4;
   localparam int WB_MBUS_W = WB_DW + WB_CTIW + WB_SELW + WB_AW + 3;

   // Arbiter helper works on a fixed-width vector; NUM_MASTERS must not exceed it.
   localparam int RR_MAX = 32;
   localparam int RR_IW  = 5;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [WB_DW-1:0]   dat;
      logic [WB_AW-1:0]   adr;
      logic [WB_CTIW-1:0] cti;
      logic [WB_SELW-1:0] sel;
      logic               we;
      logic               cyc;
      logic               stb;
   } wb_mbus_t;

   // First requester strictly after the one-hot 'last' in circular order over n entries.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input logic [RR_MAX-1:0] last,
                                                 input int                n);
      int                li;
      int                idx;
      logic [RR_MAX-1:0] g;
      li = 0;
      g  = '0;
      for (int i = 0; i < RR_MAX; i++) begin
         if (i < n && last[RR_IW'(i)]) li = i;
      end
      for (int k = 1; k <= RR_MAX; k++) begin
         if (k <= n) begin
            idx = li + k;
            if (idx >= n) idx = idx - n;
            if (req[RR_IW'(idx)] && g == '0) g[RR_IW'(idx)] = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/conbus_rr_if.sv
// Bundle of master-side and slave-side Wishbone signals around the interconnect.
// master: the agents attached to the bus; slave: the interconnect itself.
interface conbus_rr_if
   import conbus_pkg::*;
#(
   parameter int NM = 2,
   parameter int NS = 8
);

   logic [NM*WB_DW-1:0]   m_dat_i;
   logic [NM*WB_DW-1:0]   m_dat_o;
   logic [NM*WB_AW-1:0]   m_adr_i;
   logic [NM*WB_CTIW-1:0] m_cti_i;
   logic [NM*WB_SELW-1:0] m_sel_i;
   logic [NM-1:0]         m_we_i;
   logic [NM-1:0]         m_cyc_i;
   logic [NM-1:0]         m_stb_i;
   logic [NM-1:0]         m_ack_o;
   logic [NM-1:0]         m_err_o;

   logic [WB_DW-1:0]      s_dat_o;
   logic [WB_AW-1:0]      s_adr_o;
   logic [WB_CTIW-1:0]    s_cti_o;
   logic [WB_SELW-1:0]    s_sel_o;
   logic                  s_we_o;
   logic [NS-1:0]         s_cyc_o;
   logic [NS-1:0]         s_stb_o;
   logic [NS*WB_DW-1:0]   s_dat_i;
   logic [NS-1:0]         s_ack_i;
   logic [NS-1:0]         s_err_i;

   modport master (
      output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      output s_dat_i, s_ack_i, s_err_i
   );

   modport slave (
      input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      input  s_dat_i, s_ack_i, s_err_i
   );

endinterface

// File: rtl/conbus_rr_arb.sv
// Registered round-robin arbiter: a grant is held for as long as the owner's cyc
// stays high and hands over to the next requester with no idle cycle.
module conbus_rr_arb
   import conbus_pkg::*;
#(
   parameter int NM = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [NM-1:0] req,
   output logic [NM-1:0] gnt
);

   arb_state_e        state_q;
   logic [NM-1:0]     gnt_q;
   logic [NM-1:0]     last_q;
   logic [RR_MAX-1:0] pick_wide_unused;
   logic [NM-1:0]     pick;

   // Bits above NM are always zero since req/last are zero-extended.
   assign pick_wide_unused = rr_pick(RR_MAX'(req), RR_MAX'(last_q), NM);
   assign pick             = pick_wide_unused[NM-1:0];
   assign gnt              = gnt_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         last_q  <= NM'(1) << (NM - 1);
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (|req) begin
                  gnt_q   <= pick;
                  last_q  <= pick;
                  state_q <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               // Owner released: pick is already zero when nobody else is waiting.
               if (~|(req & gnt_q)) begin
                  gnt_q <= pick;
                  if (|req) last_q <= pick;
                  else      state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration, prefix address
// decode, selected-slave response return, default error slave and a stb watchdog.
module conbus_rr
   import conbus_pkg::*;
#(
   parameter int                                 NUM_MASTERS = 2,
   parameter int                                 NUM_SLAVES  = 8,
   parameter int                                 S_ADDR_W    = 3,
   parameter logic [NUM_SLAVES*S_ADDR_W-1:0]     S_ADDR_MAP  = 24'hFAC688,
   parameter int                                 TIMEOUT     = 255,
   parameter int                                 TIMEOUT_W   = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   conbus_rr_if.slave  bus
);

   localparam logic [TIMEOUT_W-1:0] WDT_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [NUM_MASTERS-1:0] gnt;
   wb_mbus_t               m_fld [NUM_MASTERS];
   wb_mbus_t               mbus;
   logic [NUM_SLAVES-1:0]  hit;
   logic [NUM_SLAVES-1:0]  sel;
   logic [WB_DW-1:0]       rdat;
   logic                   stb_act;
   logic                   slv_ack;
   logic                   slv_err;
   logic                   dflt_err_q, dflt_err_d;
   logic [TIMEOUT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
   logic                   wdt_err;

   conbus_rr_arb #(.NM(NUM_MASTERS)) u_arb (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .req     (bus.m_cyc_i),
      .gnt     (gnt)
   );

   // AND-OR mux: every master's bundle is masked by its grant bit.
   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mfld
      assign m_fld[i] = {WB_MBUS_W{gnt[i]}} & {bus.m_dat_i[i*WB_DW +: WB_DW],
                                               bus.m_adr_i[i*WB_AW +: WB_AW],
                                               bus.m_cti_i[i*WB_CTIW +: WB_CTIW],
                                               bus.m_sel_i[i*WB_SELW +: WB_SELW],
                                               bus.m_we_i[i], bus.m_cyc_i[i], bus.m_stb_i[i]};
   end

   always_comb begin
      mbus = '0;
      for (int i = 0; i < NUM_MASTERS; i++) mbus = mbus | m_fld[i];
   end

   for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_dec
      assign hit[k] = (mbus.adr[WB_AW-1 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]);
   end

   // Lowest matching index wins; nothing is selected while the bus is idle.
   assign sel = (|gnt) ? (hit & (~hit + NUM_SLAVES'(1))) : '0;

   always_comb begin
      rdat = '0;
      for (int k = 0; k < NUM_SLAVES; k++) rdat = rdat | (bus.s_dat_i[k*WB_DW +: WB_DW] & {WB_DW{sel[k]}});
   end

   assign stb_act = mbus.cyc & mbus.stb;
   assign slv_ack = |(sel & bus.s_ack_i);
   assign slv_err = |(sel & bus.s_err_i);

   always_comb begin
      // Default slave answers once per strobe, then stays quiet for a cycle.
      dflt_err_d = stb_act & ~(|sel) & ~dflt_err_q;
      wdt_err    = 1'b0;
      wdt_cnt_d  = '0;
      if (TIMEOUT != 0 && stb_act && !(slv_ack || slv_err || dflt_err_q)) begin
         if (wdt_cnt_q == WDT_LAST) wdt_err = 1'b1;
         else                       wdt_cnt_d = wdt_cnt_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dflt_err_q <= 1'b0;
         wdt_cnt_q  <= '0;
      end else begin
         dflt_err_q <= dflt_err_d;
         wdt_cnt_q  <= wdt_cnt_d;
      end
   end

   assign bus.s_dat_o = mbus.dat;
   assign bus.s_adr_o = mbus.adr;
   assign bus.s_cti_o = mbus.cti;
   assign bus.s_sel_o = mbus.sel;
   assign bus.s_we_o  = mbus.we;
   assign bus.s_cyc_o = sel & {NUM_SLAVES{mbus.cyc}};
   assign bus.s_stb_o = sel & {NUM_SLAVES{mbus.stb}};

   assign bus.m_dat_o = {NUM_MASTERS{rdat}};
   assign bus.m_ack_o = gnt & {NUM_MASTERS{slv_ack}};
   assign bus.m_err_o = gnt & {NUM_MASTERS{slv_err | dflt_err_q | wdt_err}};

endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr: 2 masters, 8 slaves, slave 7 aliased to prefix 0
// so 0xE000_0000 is unmapped, and a 16-cycle watchdog.
module tb_conbus_rr;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   npulse;

   conbus_rr_if #(.NM(2), .NS(8)) bus ();

   conbus_rr #(
      .NUM_MASTERS (2),
      .NUM_SLAVES  (8),
      .S_ADDR_W    (3),
      .S_ADDR_MAP  (24'h1AC688),
      .TIMEOUT     (16),
      .TIMEOUT_W   (8)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mset(input int m, input logic [31:0] adr, input logic we,
                       input logic [2:0] cti, input logic [31:0] dat);
      bus.m_cyc_i[m]          = 1'b1;
      bus.m_stb_i[m]          = 1'b1;
      bus.m_adr_i[m*32 +: 32] = adr;
      bus.m_we_i[m]           = we;
      bus.m_cti_i[m*3 +: 3]   = cti;
      bus.m_sel_i[m*4 +: 4]   = 4'hF;
      bus.m_dat_i[m*32 +: 32] = dat;
   endtask

   task automatic mdrop(input int m);
      bus.m_cyc_i[m] = 1'b0;
      bus.m_stb_i[m] = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      npulse = 0;
      rst = 1'b1;
      bus.m_dat_i = '0; bus.m_adr_i = '0; bus.m_cti_i = '0; bus.m_sel_i = '0;
      bus.m_we_i  = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
      bus.s_ack_i = '0; bus.s_err_i = '0;
      for (int k = 0; k < 8; k++) bus.s_dat_i[k*32 +: 32] = 32'hD0D0_0000 + 32'(k);

      tick(); tick();
      @(negedge clk);
      chk("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
      chk("rst_sstb", 64'(bus.s_stb_o), 64'h0);
      chk("rst_mack", 64'(bus.m_ack_o), 64'h0);
      chk("rst_merr", 64'(bus.m_err_o), 64'h0);
      chk("rst_sadr", 64'(bus.s_adr_o), 64'h0);
      chk("rst_mdat", 64'(bus.m_dat_o), 64'h0);

      // single read from m0 to slave 1, ack on the third stb cycle
      tick(); rst = 1'b0;
      mset(0, 32'h2000_0000, 1'b0, 3'b000, 32'h0);
      @(negedge clk); chk("t1_wait_stb", 64'(bus.s_stb_o), 64'h0);
      tick(); @(negedge clk);
      chk("t1_stb", 64'(bus.s_stb_o), 64'h02);
      chk("t1_cyc", 64'(bus.s_cyc_o), 64'h02);
      chk("t1_noack1", 64'(bus.m_ack_o), 64'h0);
      tick(); @(negedge clk); chk("t1_noack2", 64'(bus.m_ack_o), 64'h0);
      tick(); bus.s_ack_i[1] = 1'b1; @(negedge clk);
      chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
      chk("t1_dat", 64'(bus.m_dat_o), {32'hD0D0_0001, 32'hD0D0_0001});
      chk("t1_noerr", 64'(bus.m_err_o), 64'h0);
      tick(); mdrop(0); bus.s_ack_i = '0; @(negedge clk);
      chk("t1_end_cyc", 64'(bus.s_cyc_o), 64'h0);
      chk("t1_end_ack", 64'(bus.m_ack_o), 64'h0);

      // simultaneous requests from reset: m0 first, hand-over without a dead cycle
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      mset(0, 32'h4000_0000, 1'b0, 3'b000, 32'h0);
      mset(1, 32'h6000_0000, 1'b0, 3'b000, 32'h0);
      @(negedge clk); chk("t2_idle", 64'(bus.s_cyc_o), 64'h0);
      tick(); bus.s_ack_i[2] = 1'b1; @(negedge clk);
      chk("t2_m0_cyc", 64'(bus.s_cyc_o), 64'h04);
      chk("t2_m0_ack", 64'(bus.m_ack_o), 64'h1);
      tick(); mdrop(0); bus.s_ack_i = '0; @(negedge clk);
      chk("t2_rel_cyc", 64'(bus.s_cyc_o), 64'h0);
      tick(); bus.s_ack_i[3] = 1'b1; @(negedge clk);
      chk("t2_m1_cyc", 64'(bus.s_cyc_o), 64'h08);
      chk("t2_m1_ack", 64'(bus.m_ack_o), 64'h2);
      tick(); mdrop(1); bus.s_ack_i = '0;
      tick();
      mset(0, 32'h4000_0000, 1'b0, 3'b000, 32'h0);
      mset(1, 32'h6000_0000, 1'b0, 3'b000, 32'h0);
      tick(); bus.s_ack_i[2] = 1'b1; @(negedge clk);
      chk("t2_tie_cyc", 64'(bus.s_cyc_o), 64'h04);
      chk("t2_tie_ack", 64'(bus.m_ack_o), 64'h1);

      // m1 4-beat burst while m0 waits
      tick(); mdrop(0); bus.s_ack_i = '0;
      mset(1, 32'h6000_0000, 1'b0, 3'b010, 32'h0);
      for (int b = 0; b < 4; b++) begin
         tick();
         if (b == 0) begin
            mset(0, 32'h4000_0000, 1'b0, 3'b000, 32'h0);
            bus.s_ack_i[3] = 1'b1;
         end
         @(negedge clk);
         chk($sformatf("t3_b%0d_cyc", b), 64'(bus.s_cyc_o), 64'h08);
         chk($sformatf("t3_b%0d_ack", b), 64'(bus.m_ack_o), 64'h2);
         chk($sformatf("t3_b%0d_cti", b), 64'(bus.s_cti_o), 64'h2);
      end
      tick(); mdrop(1); bus.s_ack_i = '0; @(negedge clk);
      chk("t3_rel_cyc", 64'(bus.s_cyc_o), 64'h0);
      chk("t3_rel_ack", 64'(bus.m_ack_o), 64'h0);
      tick(); bus.s_ack_i[2] = 1'b1; @(negedge clk);
      chk("t3_m0_cyc", 64'(bus.s_cyc_o), 64'h04);
      chk("t3_m0_cti", 64'(bus.s_cti_o), 64'h0);
      chk("t3_m0_ack", 64'(bus.m_ack_o), 64'h1);
      tick(); mdrop(0); bus.s_ack_i = '0;

      // unmapped write: default slave error exactly once
      tick(); mset(0, 32'hE000_0000, 1'b1, 3'b000, 32'h1234_5678);
      tick(); @(negedge clk);
      chk("t4_stb", 64'(bus.s_stb_o), 64'h0);
      chk("t4_cyc", 64'(bus.s_cyc_o), 64'h0);
      chk("t4_we", 64'(bus.s_we_o), 64'h1);
      chk("t4_dat", 64'(bus.s_dat_o), 64'h1234_5678);
      chk("t4_err0", 64'(bus.m_err_o), 64'h0);
      tick(); @(negedge clk); chk("t4_err1", 64'(bus.m_err_o), 64'h1);
      tick(); @(negedge clk); chk("t4_err2", 64'(bus.m_err_o), 64'h0);
      tick(); mdrop(0);

      // silent slave 4: watchdog fires every 16 stb cycles
      tick(); mset(0, 32'h8000_0000, 1'b0, 3'b000, 32'h0);
      for (int c = 1; c <= 33; c++) begin
         tick(); @(negedge clk);
         if (bus.m_err_o[0]) npulse++;
         if (c == 1)  chk("t5_stb", 64'(bus.s_stb_o), 64'h10);
         if (c == 15) chk("t5_c15", 64'(bus.m_err_o), 64'h0);
         if (c == 16) chk("t5_c16", 64'(bus.m_err_o), 64'h1);
         if (c == 17) chk("t5_c17", 64'(bus.m_err_o), 64'h0);
         if (c == 17) chk("t5_stb_held", 64'(bus.s_stb_o), 64'h10);
         if (c == 32) chk("t5_c32", 64'(bus.m_err_o), 64'h1);
      end
      chk("t5_npulse", 64'(npulse), 64'd2);
      tick(); mdrop(0);

      // reset during slave wait states, then tie resolves to m0 again
      tick(); mset(0, 32'hA000_0000, 1'b0, 3'b000, 32'h0);
      tick(); @(negedge clk); chk("t6_m0_cyc", 64'(bus.s_cyc_o), 64'h20);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      mset(1, 32'hC000_0000, 1'b0, 3'b000, 32'h0);
      @(negedge clk);
      chk("t6_rst_cyc", 64'(bus.s_cyc_o), 64'h0);
      chk("t6_rst_stb", 64'(bus.s_stb_o), 64'h0);
      chk("t6_rst_ack", 64'(bus.m_ack_o), 64'h0);
      tick(); bus.s_ack_i[5] = 1'b1; @(negedge clk);
      chk("t6_prio_cyc", 64'(bus.s_cyc_o), 64'h20);
      chk("t6_prio_ack", 64'(bus.m_ack_o), 64'h1);
      tick(); mdrop(0); bus.s_ack_i = '0;
      tick(); bus.s_ack_i[6] = 1'b1; @(negedge clk);
      chk("t6_m1_cyc", 64'(bus.s_cyc_o), 64'h40);
      chk("t6_m1_ack", 64'(bus.m_ack_o), 64'h2);
      tick(); mdrop(1); bus.s_ack_i = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/conbus_rr.md
Name: conbus_rr

Overview:
Parametrised shared-bus Wishbone interconnect for the SoC. It connects NUM_MASTERS masters to NUM_SLAVES slaves through one shared path, with registered round-robin arbitration that holds the grant for the whole cycle. Addresses are decoded from a per-slave prefix map. It adds ERR responses that the fixed 2x7 bus lacks: an internal default slave for unmapped addresses and a watchdog timeout. Unlike the fixed bus, only the selected slave's ack/err is returned.

Parameters:
NUM_MASTERS, 2, number of masters (>=1)
NUM_SLAVES, 8, number of slaves (>=1)
S_ADDR_W, 3, number of address MSBs decoded, adr[31:32-S_ADDR_W]
S_ADDR_MAP, {3'd7,...,3'd0}, packed NUM_SLAVES*S_ADDR_W prefixes; slave k uses field k
TIMEOUT, 255, cycles of unanswered stb before ERR; 0 disables the watchdog
TIMEOUT_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2**TIMEOUT_W

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
m_dat_i  in  NM*32  master write data, master i in slice [i*32+:32]
m_dat_o  out  NM*32  read data, same value broadcast to every slice
m_adr_i  in  NM*32  master address
m_cti_i  in  NM*3  cycle type identifier
m_sel_i  in  NM*4  byte selects
m_we_i  in  NM  write enable
m_cyc_i  in  NM  cycle, also the arbitration request
m_stb_i  in  NM  strobe
m_ack_o  out  NM  ack, granted master only
m_err_o  out  NM  error, granted master only
s_dat_o  out  32  write data, broadcast to all slaves
s_adr_o  out  32  address, broadcast
s_cti_o  out  3  cycle type, broadcast
s_sel_o  out  4  byte selects, broadcast
s_we_o  out  1  write enable, broadcast
s_cyc_o  out  NS  per-slave cycle
s_stb_o  out  NS  per-slave strobe
s_dat_i  in  NS*32  slave read data
s_ack_i  in  NS  slave ack
s_err_i  in  NS  slave error

Behaviour:
- Clock is sys_clk; reset is sys_rst, synchronous and active-high.
- Reset state: gnt=0; last-granted pointer=NM-1, so master 0 has top priority; watchdog=0; dflt_err=0.
- Outputs after reset: all m_ack_o, m_err_o, s_cyc_o and s_stb_o are 0; the broadcast fields and m_dat_o are 0.
- Arbiter states:
  - IDLE (gnt=0): if any m_cyc_i is high, the next edge grants the first requester after the pointer in circular order, moves to BUSY and updates the pointer.
  - BUSY: the grant holds while the granted master's cyc is high. Other requests are ignored.
  - BUSY release: at the edge where the granted cyc is low, the grant moves straight to the next requester in round-robin order, or to IDLE if none. There is no dead cycle between masters.
- Latency: a master raising cyc on an idle bus sees its signals on the slave side one cycle later. The return path is combinational: slave ack goes to m_ack_o in the same cycle.
- Shared bus: the granted master's fields are AND-OR muxed onto s_*_o. When gnt=0 all fields are 0.
- Decode: sel[k]=1 when adr[31:32-S_ADDR_W] equals the k-th map field. If several slaves match, the lowest index wins, so sel is one-hot.
- s_cyc_o[k] = granted cyc & sel[k]; s_stb_o[k] = granted stb & sel[k].
- Read data: m_dat_o = s_dat_i of the selected slave, 0 if no slave is selected.
- m_ack_o[g] = s_ack_i[sel]. Acks from unselected slaves are ignored.
- Unmapped address (no sel): the internal default slave registers dflt_err=1 one cycle after stb, for one cycle only. It then clears even if stb stays high, and re-fires only after ack/err has been returned.
- m_err_o[g] = s_err_i[sel] | dflt_err | wdt_err.
- Watchdog: the counter increments each cycle the granted stb is high with no ack/err. It clears when stb is low, on ack/err, or on a grant change. When it reaches TIMEOUT, wdt_err pulses for one cycle and the counter clears. The slave strobe is not withdrawn; the master must end the cycle.
- Simultaneous slave ack and err: both are forwarded; the master treats err as dominant.
- Reset mid-cycle: at the reset edge, grant and counters clear and all strobes drop. Any in-flight transfer is abandoned with no ack.
- A grant change never occurs while the granted cyc is high, including during CTI bursts.

Decomposition:
- Package conbus_pkg holds:
  - constants WB_DW=32, WB_CTIW=3, WB_SELW=4;
  - the master-field bundle width WB_MBUS_W=32+3+4+32+3;
  - function rr_pick(req, last) returning a one-hot grant.
- Sub-module conbus_rr_arb (sys_clk, sys_rst, req[NM], gnt[NM]) contains the state machine and pointer.
- Decode, muxing, default slave and watchdog stay in conbus_rr.

Test Plan:
1. NM=2: m0 reads adr 0x2000_0000 (slave 1), slave acks after 3 cycles -> s_stb_o=8'b0000_0010 from cycle 1; m_ack_o=2'b01 with the slave ack cycle; m_dat_o=s_dat_i slice 1.
2. m0 and m1 raise cyc in the same cycle from reset -> m0 granted first; at the edge where m0 drops cyc, m1 is granted; a later tie grants m0 again.
3. m1 holds cyc over a 4-beat CTI=3'b010 burst while m0 requests -> m0 is not granted until m1's cyc falls; all 4 acks go to m1 only.
4. S_ADDR_MAP with slave 7 mapped to 3'd0 as well, access 0xE000_0000 where no prefix matches -> no s_stb_o; m_err_o pulses for exactly 1 cycle, one cycle after stb.
5. TIMEOUT=16, selected slave never responds -> m_err_o pulses on the 16th stb cycle; the counter restarts; a second pulse follows 16 cycles later if stb is still held.
6. Assert sys_rst during slave wait states -> s_cyc_o=0 and gnt=0 the cycle after; a subsequent m1 request is granted normally and master 0 priority is restored.
